// File: rtl/iobus_uart_pkg.sv
// ---------------------------------------------------------------------------
// iobus_uart_pkg
// Shared definitions for the IOBUS UART transmitter:
//   - tx_state_t       : serialiser FSM states
//   - *_AD_DEFAULT     : default IOBUS addresses of the data and status ports
//   - ST_*             : bit positions inside the status word
// ---------------------------------------------------------------------------
package iobus_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] DATA_AD_DEFAULT   = 32'h1120_0000;
    localparam logic [31:0] STATUS_AD_DEFAULT = 32'h1120_0004;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;

endpackage

// File: rtl/sync_byte_fifo.sv
// ---------------------------------------------------------------------------
// sync_byte_fifo
// Single-clock byte FIFO with registered pointers and a first-word
// fall-through read port (o_pop_data shows the head entry).
// Ports:
//   CLK, RESET   : clock, synchronous active-high reset
//   i_push       : push request; taken when not full, or when full and a
//                  pop happens in the same cycle
//   i_push_data  : byte to push
//   i_pop        : pop request; ignored when empty
//   o_pop_data   : head entry
//   o_full       : count == DEPTH
//   o_empty      : count == 0
//   o_count      : number of stored bytes
// ---------------------------------------------------------------------------
module sync_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop   = i_pop && (r_count != {(AW + 1){1'b0}});
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push  = i_push && ((r_count != FULL_COUNT) || w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == {(AW + 1){1'b0}});
    assign o_count    = r_count;

    // Storage array write port
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// ---------------------------------------------------------------------------
// iobus_uart_tx
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS. Bytes written to
// DATA_AD are queued and sent LSB first; STATUS_AD reads back the status word
// and a write with bit3 set clears the sticky OVERRUN flag.
// Ports:
//   CLK, RESET  : MCU clock, synchronous active-high reset
//   IOBUS_ADDR  : bus address
//   IOBUS_OUT   : bus write data
//   IOBUS_WR    : single-cycle write strobe
//   RD_DATA     : status word when IOBUS_ADDR == STATUS_AD, else 0 (comb.)
//   TX          : serial line, idle high (registered)
//   BUSY        : FIFO non-empty or frame in progress (registered)
// ---------------------------------------------------------------------------
module iobus_uart_tx
    import iobus_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] DATA_AD      = DATA_AD_DEFAULT,
    parameter logic [31:0] STATUS_AD    = STATUS_AD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        TX,
    output logic        BUSY
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    tx_state_t                   r_state;
    tx_state_t                   w_state_next;
    logic [BW-1:0]               r_baud;
    logic [BW-1:0]               w_baud_next;
    logic [2:0]                  r_bit;
    logic [2:0]                  w_bit_next;
    logic [7:0]                  r_shift;
    logic [7:0]                  w_shift_next;
    logic                        r_tx;
    logic                        w_tx_next;
    logic                        r_busy;
    logic                        w_busy_next;
    logic                        r_overrun;

    logic                        w_wr_data;
    logic                        w_wr_status;
    logic                        w_pop;
    logic                        w_push_ok;
    logic                        w_overrun_set;
    logic                        w_baud_last;
    logic [7:0]                  w_pop_data;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_unused;

    assign w_wr_data     = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
    assign w_wr_status   = IOBUS_WR && (IOBUS_ADDR == STATUS_AD);
    assign w_push_ok     = w_wr_data && (!w_full || w_pop);
    assign w_overrun_set = w_wr_data && w_full && !w_pop;
    assign w_baud_last   = (r_baud == BAUD_LAST);
    assign w_unused      = &{1'b0, IOBUS_OUT[31:8]};

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_push      (w_wr_data),
        .i_push_data (IOBUS_OUT[7:0]),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Serialiser next-state, counters, pop request and next line level
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;

        case (r_state)
            IDLE: begin
                w_baud_next = {BW{1'b0}};
                w_bit_next  = 3'd0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_pop_data;
                    w_state_next = START;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_baud_next  = {BW{1'b0}};
                    w_state_next = DATA;
                end else begin
                    w_baud_next  = r_baud + BAUD_ONE;
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_next  = {BW{1'b0}};
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_state_next = DATA;
                    end
                end else begin
                    w_baud_next  = r_baud + BAUD_ONE;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_next = {BW{1'b0}};
                    w_bit_next  = 3'd0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_pop_data;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next  = r_baud + BAUD_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_baud_next  = {BW{1'b0}};
                w_bit_next   = 3'd0;
            end
        endcase

        // The line register follows the state being entered, so TX changes on
        // the same edge as the state.
        case (w_state_next)
            IDLE:    w_tx_next = 1'b1;
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            STOP:    w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase

        // When staying idle no pop occurred, so the FIFO is non-empty after
        // the edge iff it is non-empty now or a push is accepted.
        w_busy_next = (w_state_next != IDLE) || !w_empty || w_push_ok;
    end

    // Serialiser state, counters and shift register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    // Registered serial line and busy flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (w_wr_status && IOBUS_OUT[3]) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    // Status read mux
    always_comb begin
        RD_DATA = 32'h0000_0000;
        if (IOBUS_ADDR == STATUS_AD) begin
            RD_DATA[ST_FULL]                       = w_full;
            RD_DATA[ST_EMPTY]                      = w_empty;
            RD_DATA[ST_ACTIVE]                     = (r_state != IDLE);
            RD_DATA[ST_OVERRUN]                    = r_overrun;
            RD_DATA[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(w_count);
        end else begin
            RD_DATA = 32'h0000_0000;
        end
    end

    assign TX   = r_tx;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_iobus_uart_tx
// Directed and randomized stimulus for iobus_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). A frame-timeline model (byte queue, current byte, position
// inside the 10-bit frame) predicts TX, BUSY and RD_DATA every cycle.
// ---------------------------------------------------------------------------
module tb_iobus_uart_tx;

    localparam int          CPB         = 4;
    localparam int          DEPTH       = 4;
    localparam int          FRAME       = 10 * CPB;
    localparam logic [31:0] DATA_AD     = 32'h1120_0000;
    localparam logic [31:0] STATUS_AD   = 32'h1120_0004;
    localparam logic [31:0] UNMAPPED_AD = 32'h1120_0008;

    logic        CLK;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        TX;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_in_frame;
    int         m_pos;
    bit         m_ovr;

    // Last sampled DUT outputs
    logic        last_tx;
    logic        last_busy;
    logic [31:0] last_rd;

    iobus_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_AD      (DATA_AD),
        .STATUS_AD    (STATUS_AD)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .RD_DATA    (RD_DATA),
        .TX         (TX),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_tx();
        int idx;
        if (!m_in_frame) return 1'b1;
        idx = m_pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx - 1];
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] addr);
        if (addr != STATUS_AD) return 32'd0;
        return {23'd0, 5'(m_q.size()), m_ovr, m_in_frame,
                (m_q.size() == 0), (m_q.size() == DEPTH)};
    endfunction

    // Advance the model by one clock edge with the inputs sampled on it.
    task automatic model_edge(input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic rst);
        bit full_before;
        bit popped;
        bit set_now;
        full_before = (m_q.size() == DEPTH);
        popped      = 1'b0;
        set_now     = 1'b0;
        if (rst) begin
            m_q.delete();
            m_in_frame = 1'b0;
            m_pos      = 0;
            m_ovr      = 1'b0;
        end else begin
            if (m_in_frame) begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_pos = 0;
                    if (m_q.size() > 0) begin
                        m_cur  = m_q.pop_front();
                        popped = 1'b1;
                    end else begin
                        m_in_frame = 1'b0;
                    end
                end
            end else if (m_q.size() > 0) begin
                m_cur      = m_q.pop_front();
                m_in_frame = 1'b1;
                m_pos      = 0;
                popped     = 1'b1;
            end
            if (wr && addr == DATA_AD) begin
                if (!full_before || popped) begin
                    m_q.push_back(data[7:0]);
                end else begin
                    m_ovr   = 1'b1;
                    set_now = 1'b1;
                end
            end
            if (wr && addr == STATUS_AD && data[3] && !set_now) m_ovr = 1'b0;
        end
    endtask

    // One bus cycle: drive, clock, update model, sample on the falling edge.
    task automatic step(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic rst);
        IOBUS_WR   = wr;
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        RESET      = rst;
        @(posedge CLK);
        model_edge(wr, addr, data, rst);
        @(negedge CLK);
        last_tx   = TX;
        last_busy = BUSY;
        last_rd   = RD_DATA;
        check("tx", 32'(TX), 32'(m_tx()));
        check("busy", 32'(BUSY), 32'(m_in_frame || (m_q.size() > 0)));
        check("rd_data", RD_DATA, m_rd(addr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, STATUS_AD, 32'd0, 1'b0);
    endtask

    initial begin
        logic [9:0] frame_a5;
        int         n;
        int         sel;
        logic [31:0] raddr;

        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = STATUS_AD;
        IOBUS_OUT  = 32'd0;
        RESET      = 1'b1;
        m_in_frame = 1'b0;
        m_pos      = 0;
        m_ovr      = 1'b0;
        m_cur      = 8'h00;

        // Reset state
        step(1'b0, STATUS_AD, 32'd0, 1'b1);
        step(1'b0, STATUS_AD, 32'd0, 1'b1);
        check("reset_tx", 32'(last_tx), 32'd1);
        check("reset_busy", 32'(last_busy), 32'd0);
        check("reset_status", last_rd, 32'h2);

        // Status decode while idle
        idle(2);
        check("idle_status", last_rd, 32'h2);
        step(1'b0, UNMAPPED_AD, 32'd0, 1'b0);
        check("unmapped_rd", last_rd, 32'h0);

        // Single byte 0xA5: exact line sequence and BUSY edges
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        step(1'b1, DATA_AD, 32'h0000_00A5, 1'b0);
        check("a5_busy_rise", 32'(last_busy), 32'd1);
        check("a5_tx_before_pop", 32'(last_tx), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, STATUS_AD, 32'd0, 1'b0);
            check("a5_line", 32'(last_tx), 32'(frame_a5[k / CPB]));
        end
        check("a5_busy_last", 32'(last_busy), 32'd1);
        idle(1);
        check("a5_busy_fall", 32'(last_busy), 32'd0);
        check("a5_status_after", last_rd, 32'h2);

        // Back-to-back 0x00 then 0xFF: BUSY never drops between frames
        step(1'b1, DATA_AD, 32'h0000_0000, 1'b0);
        step(1'b1, DATA_AD, 32'h0000_00FF, 1'b0);
        for (int k = 0; k < 2 * FRAME - 1; k++) begin
            idle(1);
            check("b2b_busy", 32'(last_busy), 32'd1);
        end
        idle(1);
        check("b2b_busy_fall", 32'(last_busy), 32'd0);

        // Overrun: six writes in six cycles, sixth dropped
        for (int k = 0; k < 6; k++) step(1'b1, DATA_AD, 32'($urandom_range(255)), 1'b0);
        idle(1);
        check("ovr_flag", 32'(last_rd[3]), 32'd1);
        check("ovr_count", 32'(last_rd[8:4]), 32'd4);
        n = 0;
        while (last_busy && n < 400) begin
            idle(1);
            n++;
        end
        check("ovr_drain_bound", 32'(n < 400), 32'd1);
        check("ovr_still_set", 32'(last_rd[3]), 32'd1);
        step(1'b1, STATUS_AD, 32'h0000_0008, 1'b0);
        idle(1);
        check("ovr_cleared", last_rd, 32'h2);

        // Full FIFO with a write on the STOP-end pop cycle
        for (int k = 0; k < 5; k++) step(1'b1, DATA_AD, 32'($urandom_range(255)), 1'b0);
        n = 0;
        while (!(m_in_frame && m_pos == FRAME - 1) && n < 60) begin
            idle(1);
            n++;
        end
        check("fullpop_wait_bound", 32'(n < 60), 32'd1);
        check("fullpop_full_before", 32'(last_rd[0]), 32'd1);
        step(1'b1, DATA_AD, 32'h0000_005A, 1'b0);
        idle(1);
        check("fullpop_status", last_rd, 32'h45);
        n = 0;
        while (last_busy && n < 400) begin
            idle(1);
            n++;
        end
        check("fullpop_drain_bound", 32'(n < 400), 32'd1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(29));
            if (sel < 4) begin
                step(1'b1, DATA_AD, $urandom, 1'b0);
            end else if (sel == 4) begin
                step(1'b1, STATUS_AD, $urandom, 1'b0);
            end else begin
                raddr = (sel < 20) ? STATUS_AD : ((sel < 25) ? UNMAPPED_AD : $urandom);
                step(1'b0, raddr, $urandom, 1'b0);
            end
        end
        n = 0;
        while (last_busy && n < 400) begin
            idle(1);
            n++;
        end
        check("rand_drain_bound", 32'(n < 400), 32'd1);

        // Reset in the middle of data bit 3
        step(1'b1, DATA_AD, 32'h0000_003C, 1'b0);
        step(1'b1, DATA_AD, 32'h0000_00C3, 1'b0);
        n = 0;
        while (!(m_in_frame && m_pos == 4 * CPB + 1) && n < 60) begin
            idle(1);
            n++;
        end
        check("rst_wait_bound", 32'(n < 60), 32'd1);
        step(1'b0, STATUS_AD, 32'd0, 1'b1);
        check("rst_mid_tx", 32'(last_tx), 32'd1);
        check("rst_mid_busy", 32'(last_busy), 32'd0);
        check("rst_mid_status", last_rd, 32'h2);
        for (int k = 0; k < 2 * FRAME; k++) begin
            idle(1);
            check("rst_quiet_tx", 32'(last_tx), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
